// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 8-bit processor.
// Drives the program counter, instruction fetch, register file strobes and ALU operands.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  pc,
  output logic        ir_en,
  input  logic [15:0] ir_data,
  output logic [1:0]  reg_addr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [7:0]  reg_din,
  input  logic [7:0]  reg_dout,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out,
  output logic        halted,
  output logic        instr_done
);

  localparam logic [2:0] FETCH1 = 3'd0;
  localparam logic [2:0] FETCH2 = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] RDA    = 3'd3;
  localparam logic [2:0] RDB    = 3'd4;
  localparam logic [2:0] EXEC   = 3'd5;
  localparam logic [2:0] WB     = 3'd6;
  localparam logic [2:0] HALT   = 3'd7;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_HLT  = 4'b1100;
  localparam logic [3:0] OP_DJNZ = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  logic [2:0] state, state_nx;
  logic       run_q;
  logic       halt_entry;
  // Only decoded fields are kept; ir[11:10] are reserved and ignored.
  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] imm_q;
  logic [7:0] a_q, b_q, r_q;
  logic [7:0] a_hold, b_hold;
  logic [2:0] op_hold;
  logic       is_arith, is_unary, decode_done;
  logic [2:0] exec_op;
  logic [1:0] ra, rb;

  assign ra          = imm_q[5:4];
  assign rb          = imm_q[1:0];
  assign is_arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_unary    = (op_q == OP_INC) || (op_q == OP_DEC) || (op_q == OP_DJNZ);
  assign exec_op     = ((op_q == OP_ADD) || (op_q == OP_INC)) ? 3'b000 : 3'b001;
  // JMP and every unlisted opcode retire in DECODE
  assign decode_done = !(is_arith || is_unary || (op_q == OP_LOAD) || (op_q == OP_HLT));

  always_comb begin
    state_nx = state;
    case (state)
      FETCH1: state_nx = FETCH2;
      FETCH2: state_nx = DECODE;
      DECODE: begin
        if (op_q == OP_LOAD)           state_nx = WB;
        else if (is_arith || is_unary) state_nx = RDA;
        else if (op_q == OP_HLT)       state_nx = HALT;
        else                           state_nx = FETCH1;
      end
      RDA:     state_nx = is_arith ? RDB : EXEC;
      RDB:     state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = FETCH1;
      default: state_nx = state;
    endcase
  end

  // run_q holds the machine idle until the first edge after reset release,
  // so that edge is the one that starts FETCH1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH1;
      run_q      <= 1'b0;
      halt_entry <= 1'b0;
      pc         <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      a_hold     <= '0;
      b_hold     <= '0;
      op_hold    <= '0;
    end else begin
      run_q      <= 1'b1;
      halt_entry <= 1'b0;
      if (run_q) begin
        state <= state_nx;
        case (state)
          FETCH2: begin
            op_q  <= ir_data[15:12];
            rd_q  <= ir_data[9:8];
            imm_q <= ir_data[7:0];
          end
          DECODE: begin
            if (decode_done) pc <= (op_q == OP_JMP) ? imm_q : pc + 8'd1;
            halt_entry <= (op_q == OP_HLT);
          end
          RDA: begin
            a_q <= reg_dout;
            if (is_unary) b_q <= 8'h01;
          end
          RDB: b_q <= reg_dout;
          EXEC: begin
            r_q     <= alu_out;
            a_hold  <= a_q;
            b_hold  <= b_q;
            op_hold <= exec_op;
          end
          WB: pc <= ((op_q == OP_DJNZ) && (r_q != '0)) ? imm_q : pc + 8'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ir_en    = 1'b0;
    reg_rd   = 1'b0;
    reg_wr   = 1'b0;
    reg_addr = '0;
    reg_din  = '0;
    if (run_q) begin
      case (state)
        FETCH1, FETCH2: ir_en = 1'b1;
        RDA: begin
          reg_rd   = 1'b1;
          reg_addr = is_arith ? ra : rd_q;
        end
        RDB: begin
          reg_rd   = 1'b1;
          reg_addr = rb;
        end
        WB: begin
          reg_wr   = 1'b1;
          reg_addr = rd_q;
          reg_din  = (op_q == OP_LOAD) ? imm_q : r_q;
        end
        default: ;
      endcase
    end
  end

  assign alu_a      = (state == EXEC) ? a_q     : a_hold;
  assign alu_b      = (state == EXEC) ? b_q     : b_hold;
  assign alu_opcode = (state == EXEC) ? exec_op : op_hold;
  assign halted     = (state == HALT);
  assign instr_done = (state == WB) || ((state == DECODE) && decode_done) || halt_entry;

endmodule
